// File: rtl/maple_pkg.sv
// Shared Maple transmitter definitions: FSM states, framing slot patterns and
// the Maple command codes used by frame builders upstream of maple_out.
package maple_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StGuardPre,
        StStart,
        StData,
        StCrc,
        StEnd,
        StGuardPost
    } maple_state_e;

    localparam int unsigned START_SLOTS = 10;
    localparam int unsigned END_SLOTS   = 6;

    // Bit i holds the pin level during slot i of the pattern.
    localparam logic [9:0] START_PIN1 = 10'b10_0000_0000;
    localparam logic [9:0] START_PIN5 = 10'b11_0101_0101;
    localparam logic [5:0] END_PIN1   = 6'b11_0101;
    localparam logic [5:0] END_PIN5   = 6'b10_0000;

    localparam logic [7:0] MAPLE_CMD_DEVICE_REQUEST     = 8'h01;
    localparam logic [7:0] MAPLE_CMD_ALL_STATUS_REQUEST = 8'h02;
    localparam logic [7:0] MAPLE_CMD_RESET_DEVICE       = 8'h03;
    localparam logic [7:0] MAPLE_CMD_KILL_DEVICE        = 8'h04;
    localparam logic [7:0] MAPLE_CMD_DEVICE_STATUS      = 8'h05;
    localparam logic [7:0] MAPLE_CMD_DATA_TRANSFER      = 8'h08;
    localparam logic [7:0] MAPLE_CMD_GET_CONDITION      = 8'h09;
    localparam logic [7:0] MAPLE_CMD_GET_MEDIA_INFO     = 8'h0A;
    localparam logic [7:0] MAPLE_CMD_BLOCK_READ         = 8'h0B;
    localparam logic [7:0] MAPLE_CMD_BLOCK_WRITE        = 8'h0C;
    localparam logic [7:0] MAPLE_CMD_SET_CONDITION      = 8'h0E;

    // Payload bytes for a frame whose first byte is word count L: 4*(L+1).
    function automatic logic [10:0] frame_len(input logic [7:0] word_count);
        return {1'b0, word_count, 2'b00} + 11'd4;
    endfunction

endpackage

// File: rtl/maple_out_if.sv
// Byte stream handshake between a frame builder and the Maple transmitter.
interface maple_out_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/maple_slot_timer.sv
// Slot pacing: strobes slot_end on the last cycle of every PHASE_CYCLES-long
// slot while enabled; held at the reload value when disabled.
module maple_slot_timer #(
    parameter int unsigned PHASE_CYCLES = 13
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic slot_end
);

    localparam int unsigned CW = $clog2(PHASE_CYCLES);
    localparam logic [CW-1:0] RELOAD = CW'(PHASE_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: reload when idle or at slot end, otherwise count down.
    always_comb begin
        cnt_d = cnt_q;
        if (!en || cnt_q == '0) begin
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign slot_end = en && (cnt_q == '0);

endmodule

// File: rtl/maple_out.sv
// Maple bus transmitter: frames an upstream byte stream with guard, start,
// XOR CRC and end patterns and drives SDCKA/SDCKB with the two-slot bit code.
module maple_out
    import maple_pkg::*;
#(
    parameter int unsigned PHASE_CYCLES = 13
) (
    input  logic         clk,
    input  logic         reset_n,
    maple_out_if.slave   tx,
    output logic         pin1_out,
    output logic         pin5_out,
    output logic         oe,
    output logic         busy,
    output logic         done,
    output logic         underrun
);

    maple_state_e state_q, state_d;
    logic [3:0]   slot_q, slot_d;
    logic [7:0]   hold_q, hold_d;
    logic         hold_full_q, hold_full_d;
    logic [7:0]   shift_q, shift_d;
    logic [7:0]   crc_q, crc_d;
    logic [10:0]  n_q, n_d;
    logic [10:0]  acc_q, acc_d;
    logic [10:0]  sent_q, sent_d;
    logic         under_q, under_d;
    logic         pin1_q, pin1_d, pin5_q, pin5_d;
    logic         oe_q, oe_d, busy_q, busy_d;
    logic         done_q, done_d, underrun_q, underrun_d;
    logic         ready_q, ready_d;
    logic         slot_end, hs, byte_bound;

    maple_slot_timer #(
        .PHASE_CYCLES (PHASE_CYCLES)
    ) u_slot_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (state_q != StIdle),
        .slot_end (slot_end)
    );

    assign hs = tx.tx_valid && ready_q;

    // Pin levels for a given slot; data slots alternate the clocking line per bit.
    function automatic logic [1:0] slot_pins(input maple_state_e st, input logic [3:0] slot,
                                             input logic [7:0] data);
        logic [1:0] pins;
        logic [2:0] bit_idx;
        logic       d;
        bit_idx = slot[3:1];
        d       = data[3'd7 - bit_idx];
        case (st)
            StStart: pins = {START_PIN1[slot], START_PIN5[slot]};
            StEnd:   pins = {END_PIN1[slot[2:0]], END_PIN5[slot[2:0]]};
            StData, StCrc: begin
                if (!bit_idx[0]) pins = {~slot[0], d};
                else             pins = {d, ~slot[0]};
            end
            default: pins = 2'b11;
        endcase
        return pins;
    endfunction

    // Next-state logic: FSM, byte boundaries, holding/shift registers and outputs.
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        crc_d       = crc_q;
        n_d         = n_q;
        acc_d       = acc_q;
        sent_d      = sent_q;
        under_d     = under_q;
        done_d      = 1'b0;
        underrun_d  = 1'b0;
        byte_bound  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (hs) begin
                    hold_d      = tx.tx_data;
                    hold_full_d = 1'b1;
                    n_d         = frame_len(tx.tx_data);
                    acc_d       = 11'd1;
                    sent_d      = '0;
                    crc_d       = '0;
                    under_d     = 1'b0;
                    slot_d      = '0;
                    state_d     = StGuardPre;
                end
            end
            StGuardPre: begin
                if (slot_end) begin
                    state_d = StStart;
                    slot_d  = '0;
                end
            end
            StStart: begin
                if (slot_end) begin
                    if (slot_q == 4'(START_SLOTS - 1)) byte_bound = 1'b1;
                    else                               slot_d = slot_q + 4'd1;
                end
            end
            StData: begin
                if (slot_end) begin
                    if (slot_q == 4'd15) byte_bound = 1'b1;
                    else                 slot_d = slot_q + 4'd1;
                end
            end
            StCrc: begin
                if (slot_end) begin
                    if (slot_q == 4'd15) begin
                        state_d = StEnd;
                        slot_d  = '0;
                    end else begin
                        slot_d = slot_q + 4'd1;
                    end
                end
            end
            StEnd: begin
                if (slot_end) begin
                    if (slot_q == 4'(END_SLOTS - 1)) begin
                        state_d = StGuardPost;
                        slot_d  = '0;
                    end else begin
                        slot_d = slot_q + 4'd1;
                    end
                end
            end
            StGuardPost: begin
                if (slot_end) begin
                    state_d     = StIdle;
                    hold_full_d = 1'b0;
                    done_d      = !under_q;
                    underrun_d  = under_q;
                end
            end
            default: state_d = StIdle;
        endcase

        // All payload sent -> CRC; next byte waiting -> load it; else abort to END.
        if (byte_bound) begin
            slot_d = '0;
            if (sent_q == n_q) begin
                shift_d = crc_q;
                state_d = StCrc;
            end else if (hold_full_q) begin
                shift_d     = hold_q;
                crc_d       = crc_q ^ hold_q;
                hold_full_d = 1'b0;
                sent_d      = sent_q + 11'd1;
                state_d     = StData;
            end else begin
                under_d = 1'b1;
                state_d = StEnd;
            end
        end

        if (state_q != StIdle && hs) begin
            hold_d      = tx.tx_data;
            hold_full_d = 1'b1;
            acc_d       = acc_q + 11'd1;
        end

        ready_d = (state_d == StIdle) ||
                  ((state_d inside {StGuardPre, StStart, StData}) && !hold_full_d &&
                   (acc_d < n_d));
        oe_d    = (state_d != StIdle);
        busy_d  = (state_d != StIdle);
        {pin1_d, pin5_d} = slot_pins(state_d, slot_d, shift_d);
    end

    // State and registered outputs; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            slot_q      <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            crc_q       <= '0;
            n_q         <= '0;
            acc_q       <= '0;
            sent_q      <= '0;
            under_q     <= 1'b0;
            pin1_q      <= 1'b1;
            pin5_q      <= 1'b1;
            oe_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            crc_q       <= crc_d;
            n_q         <= n_d;
            acc_q       <= acc_d;
            sent_q      <= sent_d;
            under_q     <= under_d;
            pin1_q      <= pin1_d;
            pin5_q      <= pin5_d;
            oe_q        <= oe_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            underrun_q  <= underrun_d;
            ready_q     <= ready_d;
        end
    end

    assign tx.tx_ready = ready_q;
    assign pin1_out    = pin1_q;
    assign pin5_out    = pin5_q;
    assign oe          = oe_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_maple_out.sv
// Directed bench for maple_out with PHASE_CYCLES=4: slot-by-slot pin checks
// against the expected Maple waveform, handshake counts, underrun and reset.
module tb_maple_out;
    import maple_pkg::*;

    localparam int unsigned P = 4;
    localparam logic [1:0] START_SEQ [10] = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01,
                                               2'b00, 2'b01, 2'b00, 2'b01, 2'b11};
    localparam logic [1:0] END_SEQ [6] = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b11};

    logic clk = 1'b0;
    logic reset_n;
    logic pin1, pin5, oe, busy, done, underrun;
    int   errors = 0;
    int   checks = 0;
    int   hs_cnt, late_cnt;
    logic [7:0] tx_bytes[$];
    logic [7:0] wire_bytes[$];
    logic [1:0] exp_slots[$];

    maple_out_if bus();

    maple_out #(
        .PHASE_CYCLES (P)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .tx       (bus),
        .pin1_out (pin1),
        .pin5_out (pin5),
        .oe       (oe),
        .busy     (busy),
        .done     (done),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected (pin1,pin5) per slot for wire_bytes, straight from the slot tables.
    task automatic build_slots();
        logic [7:0] b;
        logic       d;
        exp_slots.delete();
        exp_slots.push_back(2'b11);
        for (int i = 0; i < 10; i++) exp_slots.push_back(START_SEQ[i]);
        for (int i = 0; i < wire_bytes.size(); i++) begin
            b = wire_bytes[i];
            for (int j = 0; j < 8; j++) begin
                d = b[7-j];
                if (j % 2 == 0) begin
                    exp_slots.push_back({1'b1, d});
                    exp_slots.push_back({1'b0, d});
                end else begin
                    exp_slots.push_back({d, 1'b1});
                    exp_slots.push_back({d, 1'b0});
                end
            end
        end
        for (int i = 0; i < 6; i++) exp_slots.push_back(END_SEQ[i]);
        exp_slots.push_back(2'b11);
    endtask

    // Feeds tx_bytes[0..nsend-1]; counts handshakes; optionally asserts reset at abort_at.
    task automatic drive(input int nsend, input bit hold_valid, input int abort_at);
        int idx = 0;
        bit finished = 0;
        hs_cnt   = 0;
        late_cnt = 0;
        for (int it = 0; it < 3000; it++) begin
            if (abort_at != 0 && it == abort_at) begin
                reset_n      = 1'b0;
                bus.tx_valid = 1'b0;
                return;
            end
            if (idx < nsend) begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = tx_bytes[idx];
            end else begin
                bus.tx_valid = hold_valid;
                bus.tx_data  = 8'hEE;
            end
            @(negedge clk);
            if (done || underrun) begin
                bus.tx_valid = 1'b0;
                finished = 1;
                break;
            end
            if (hs_cnt >= nsend && bus.tx_ready) late_cnt++;
            if (bus.tx_valid && bus.tx_ready) begin
                hs_cnt++;
                if (idx < nsend) idx++;
            end
            @(posedge clk);
            #1;
        end
        if (!finished) begin
            checks++;
            errors++;
            $display("FAIL drive_timeout: got no done/underrun within 3000 cycles, required one");
        end
    endtask

    // Checks every slot at its first and last cycle, then the end-of-frame pulse.
    task automatic monitor(input bit exp_under);
        bit seen = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (bus.tx_valid && bus.tx_ready) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL start_timeout: got no handshake in 100 cycles, required one");
            return;
        end
        @(negedge clk);
        checks++;
        if ({oe, busy} !== 2'b11) begin
            errors++;
            $display("FAIL oe_busy_after_accept: got %b required 11", {oe, busy});
        end
        for (int s = 0; s < exp_slots.size(); s++) begin
            for (int c = 0; c < P; c++) begin
                if (c == 0 || c == P - 1) begin
                    checks++;
                    if ({pin1, pin5} !== exp_slots[s]) begin
                        errors++;
                        $display("FAIL slot%0d_cyc%0d pins: got %b required %b",
                                 s, c, {pin1, pin5}, exp_slots[s]);
                    end
                end
                if (c == P - 1) begin
                    checks++;
                    if ({oe, done, underrun} !== 3'b100) begin
                        errors++;
                        $display("FAIL slot%0d ctrl oe/done/underrun: got %b required 100",
                                 s, {oe, done, underrun});
                    end
                end
                @(negedge clk);
            end
        end
        checks++;
        if ({oe, busy, done, underrun} !== {2'b00, !exp_under, exp_under}) begin
            errors++;
            $display("FAIL frame_end oe/busy/done/underrun: got %b required %b",
                     {oe, busy, done, underrun}, {2'b00, !exp_under, exp_under});
        end
        @(negedge clk);
        checks++;
        if ({done, underrun} !== 2'b00) begin
            errors++;
            $display("FAIL pulse_width done/underrun: got %b required 00", {done, underrun});
        end
    endtask

    task automatic run_frame(input int nsend, input bit hold_valid, input bit exp_under);
        build_slots();
        @(posedge clk);
        #1;
        fork
            drive(nsend, hold_valid, 0);
            monitor(exp_under);
        join
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({pin1, pin5, oe, busy} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_pins_oe_busy: got %b required 1100", {pin1, pin5, oe, busy});
        end
        checks++;
        if ({done, underrun, bus.tx_ready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_done_underrun_ready: got %b required 000",
                     {done, underrun, bus.tx_ready});
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready: got %b required 1", bus.tx_ready);
        end
    endtask

    task automatic test_frame_n4();
        tx_bytes   = '{8'h00, 8'h20, 8'h00, 8'h01};
        wire_bytes = '{8'h00, 8'h20, 8'h00, 8'h01, 8'h21};
        run_frame(4, 1'b0, 1'b0);
        checks++;
        if (hs_cnt !== 4) begin
            errors++;
            $display("FAIL n4_handshakes: got %0d required 4", hs_cnt);
        end
    endtask

    task automatic test_frame_n8();
        tx_bytes   = '{8'h01, 8'h00, 8'h20, MAPLE_CMD_GET_CONDITION,
                       8'hAA, 8'h55, 8'h0F, 8'hF0};
        wire_bytes = '{8'h01, 8'h00, 8'h20, 8'h09, 8'hAA, 8'h55, 8'h0F, 8'hF0, 8'h28};
        run_frame(8, 1'b0, 1'b0);
        checks++;
        if (hs_cnt !== 8) begin
            errors++;
            $display("FAIL n8_handshakes: got %0d required 8", hs_cnt);
        end
    endtask

    task automatic test_valid_held();
        tx_bytes   = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
                       8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB};
        wire_bytes = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
                       8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'h02};
        run_frame(12, 1'b1, 1'b0);
        checks++;
        if (hs_cnt !== 12) begin
            errors++;
            $display("FAIL held_handshakes: got %0d required 12", hs_cnt);
        end
        checks++;
        if (late_cnt !== 0) begin
            errors++;
            $display("FAIL held_ready_after_last: got %0d ready cycles required 0", late_cnt);
        end
    endtask

    task automatic test_underrun();
        tx_bytes   = '{8'h00, 8'h20, 8'h00, 8'h01};
        wire_bytes = '{8'h00, 8'h20};
        run_frame(2, 1'b0, 1'b1);
        checks++;
        if (hs_cnt !== 2) begin
            errors++;
            $display("FAIL underrun_handshakes: got %0d required 2", hs_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        tx_bytes = '{8'h00, 8'h20, 8'h00, 8'h01};
        @(posedge clk);
        #1;
        drive(4, 1'b0, 70);
        checks++;
        if ({oe, busy} !== 2'b11) begin
            errors++;
            $display("FAIL midframe_busy_before_reset: got %b required 11", {oe, busy});
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({pin1, pin5, oe, busy, done, underrun} !== 6'b110000) begin
            errors++;
            $display("FAIL midframe_reset_outputs: got %b required 110000",
                     {pin1, pin5, oe, busy, done, underrun});
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_frame_n4();
        test_frame_n8();
        test_valid_held();
        test_underrun();
        test_reset_mid_frame();
        test_frame_n4();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/maple_out.md
# maple_out

Maple bus transmitter. Serialises a byte stream from an upstream frame builder onto the Maple pins (pin1 = SDCKA, pin5 = SDCKB), and frames it with the start pattern, XOR CRC byte and end pattern. It is the driving counterpart of the passive Maple receiver. Its `oe` output drives the pad tri-state control, so the DC-side bus is only driven while a frame is in flight.

## Interface
- `PHASE_CYCLES`, default 13: clk cycles per signalling slot (≈240 ns at 54 MHz). Minimum 2.
- `clk`  in  1  core clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `tx_data`  in  8  frame byte, in wire order. The first byte of a frame is the word count L.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  byte accepted on a cycle where `tx_valid && tx_ready`.
- `pin1_out`  out  1  SDCKA drive value.
- `pin5_out`  out  1  SDCKB drive value.
- `oe`  out  1  pad output enable.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse when a frame completes normally.
- `underrun`  out  1  one-cycle pulse when a frame is aborted because the next byte was missing.

## Operation
- Reset values: `pin1_out`=1, `pin5_out`=1, `oe`=0, `busy`=0, `done`=0, `underrun`=0, `tx_ready`=0. In IDLE, `tx_ready`=1.
- Frame length: the first byte L fixes the payload at N = 4·(L+1) bytes (max 1024, 11-bit counter). The block accepts exactly N bytes. No end marker is used.
- Buffering: one holding register plus one shift register.
  - `tx_ready`=1 while the holding register is empty and fewer than N bytes have been accepted.
  - The holding register moves into the shift register at each byte boundary.
- CRC: an 8-bit XOR of all N bytes, transmitted as byte N+1.
- Bit order: MSB first. Bit index k counts globally from 0 across the frame.
- Slot encoding, two slots per bit. Each slot lasts `PHASE_CYCLES` cycles.
  - Even k: slot 0 pin1=1, pin5=d; slot 1 pin1=0, pin5=d.
  - Odd k: slot 0 pin5=1, pin1=d; slot 1 pin5=0, pin1=d.
  - No data line ever falls at a slot transition.
- FSM: IDLE → GUARD_PRE → START → DATA → CRC → END → GUARD_POST → IDLE.
  - IDLE: the first handshake loads the holding register, sets `busy`=1 and `oe`=1, and enters GUARD_PRE.
  - GUARD_PRE: 1 slot, pins 1/1.
  - START: 10 slots, (pin1,pin5) = 0/1, 0/0, 0/1, 0/0, 0/1, 0/0, 0/1, 0/0, 0/1, 1/1.
  - DATA: N bytes. CRC: 1 byte.
  - END: 6 slots, 1/0, 0/0, 1/0, 0/0, 1/0, 1/1.
  - GUARD_POST: 1 slot, pins 1/1. Then `oe`=0, `busy`=0, `done` pulses, and the FSM returns to IDLE.
- Underrun: the holding register is empty at a DATA byte boundary.
  - Skip CRC and go straight to END.
  - Pulse `underrun` when GUARD_POST ends. `done` is not pulsed.
  - Bytes already accepted are discarded.
- `tx_valid` is ignored outside IDLE while `tx_ready`=0.
- Reset asserted mid-frame: all outputs return to their reset values on the next clk edge. No end pattern is sent.

## Timing
- All outputs are registered.
- First handshake at cycle t: `oe`=1 and `busy`=1 at t+1. GUARD_PRE slot starts at t+1.
- Frame duration: (1+10+16·(N+1)+6+1)·`PHASE_CYCLES` cycles from t+1. `done` pulses in the first cycle after the last slot, the same cycle `oe` drops.
- Byte boundary (load or underrun decision): the last cycle of the final slot of the previous byte. For the first payload byte, this is the last cycle of START slot 9.
- `tx_ready` rises the cycle after a holding-register load, unless N bytes have been accepted.

## Structure
- Shared `maple_pkg`:
  - FSM state enum.
  - START and END slot pattern constants.
  - `MAPLE_CMD_*` codes.
- Sub-module `maple_slot_timer`:
  - Parameterised down-counter.
  - Outputs a `slot_end` strobe every `PHASE_CYCLES` cycles while enabled.
  - Cleared when disabled.
- Everything else (FSM, shift/holding registers, byte counter, CRC accumulator) lives in `maple_out`.

## Test plan
All scenarios use `PHASE_CYCLES`=4.
- Frame 00 20 00 01 (N=4):
  - Wire bytes 00 20 00 01 then CRC 21.
  - `done` exactly 4·(1+10+80+6+1)=392 cycles after the first-accept cycle +1.
  - pin1/pin5 match the slot tables.
- Frame with L=1, bytes 01 00 20 09 AA 55 0F F0 (N=8): CRC = XOR of all 8 bytes. Exactly 8 handshakes.
- `tx_valid` held high continuously for a 12-byte frame (L=2): exactly 12 handshakes, `tx_ready` never high after the 12th.
- Drop `tx_valid` after byte 2 of an N=4 frame:
  - END follows byte 2 directly, no CRC.
  - `underrun` pulses once, `done` stays 0, `oe` drops.
- Assert `reset_n`=0 in the middle of DATA: one cycle later pins=1/1, `oe`=0, `busy`=0. The next frame transmits cleanly.
- Loopback `pin1_out`/`pin5_out` into the Maple receiver:
  - Decoded bytes equal the input bytes plus CRC.
  - Start and end are detected once each.
  - No spurious bits.
